// File: rtl/multi_seg_loader_pkg.sv
// multi_seg_loader_pkg: shared loader FSM encoding, control-state bundle
// and default segment base addresses.
package multi_seg_loader_pkg;

  localparam int SL_SEG_W = 3;

  localparam logic [24:0] SL_BASE_T = 25'h000_0100;
  localparam logic [24:0] SL_BASE_L = 25'h004_0000;
  localparam logic [24:0] SL_BASE_I = 25'h100_0000;

  typedef enum logic {
    SL_SIZE = 1'b0,
    SL_DATA = 1'b1
  } sl_state_e;

  typedef struct packed {
    sl_state_e             st;
    logic [SL_SEG_W-1:0]   seg;
  } sl_ctl_t;

  function automatic logic [SL_SEG_W-1:0] sl_next_seg(
    input logic [SL_SEG_W-1:0] seg,
    input int unsigned         nsegs
  );
    if (32'(seg) == nsegs - 1)
      return '0;
    return seg + SL_SEG_W'(1);
  endfunction

endpackage

// File: rtl/multi_seg_loader_word_packer.sv
// sl_word_packer: gathers strobed bytes MSB-first into one DATA_W word.
// clr_i drops any partial word and masks a coincident strobe.
module sl_word_packer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_i,
  input  logic              stb_i,
  input  logic              clr_i,
  output logic [DATA_W-1:0] word,
  output logic              word_valid
);

  localparam int NB = DATA_W / 8;
  localparam int IW = $clog2(NB);

  logic [IW-1:0]       idx_q;
  logic [DATA_W-9:0]   acc_q;
  logic                take;
  logic                last;

  assign take       = stb_i & ~clr_i;
  assign last       = (idx_q == IW'(NB - 1));
  assign word       = {acc_q, byte_i};
  assign word_valid = take & last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= '0;
      acc_q <= '0;
    end else if (clr_i) begin
      idx_q <= '0;
      acc_q <= '0;
    end else if (take) begin
      if (last) begin
        idx_q <= '0;
        acc_q <= '0;
      end else begin
        idx_q <= idx_q + IW'(1);
        acc_q <= word[DATA_W-9:0];
      end
    end
  end

endmodule

// File: rtl/multi_seg_loader.sv
// multi_seg_loader: streams XMODEM payload words into per-segment memory.
// Block checkpoint/rollback is built only when SL_CHECKPOINT_EN is defined.
module multi_seg_loader
  import multi_seg_loader_pkg::*;
#(
  parameter int NUM_SEGS = 3,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 25,
  parameter logic [NUM_SEGS*ADDR_W-1:0] BASE_ADDRS =
    {SL_BASE_I, SL_BASE_L, SL_BASE_T}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        xmodem_data_byte,
  input  logic              xmodem_saw_valid_msg_byte,
  input  logic              xmodem_saw_valid_block,
  input  logic              xmodem_saw_invalid_block,
  input  logic              xmodem_done,
  output logic [ADDR_W-1:0] sl_addr,
  output logic [DATA_W-1:0] sl_io,
  output logic              sl_we,
  input  logic              sl_ack,
  output logic [2:0]        sl_seg,
  output logic              sl_overrun,
  output logic              sl_done
);

  localparam logic [ADDR_W-1:0] BASE0 = BASE_ADDRS[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

  function automatic logic [ADDR_W-1:0] base_of(
    input logic [SL_SEG_W-1:0] s
  );
    return BASE_ADDRS[32'(s)*ADDR_W +: ADDR_W];
  endfunction

  logic [DATA_W-1:0] word;
  logic              word_valid;
  logic              stb;

  sl_ctl_t           ctl_q, ctl_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] off_q, off_d;
  logic [ADDR_W-1:0] size_w;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] io_q;
  logic              ovr_q;
  logic              done_q;

  logic              wr_req;
  logic              wr_load;
  logic              wr_lost;

  // Bytes arriving after the transfer has finished are discarded.
  assign stb = xmodem_saw_valid_msg_byte & ~done_q;

  sl_word_packer #(
    .DATA_W (DATA_W)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .byte_i     (xmodem_data_byte),
    .stb_i      (stb),
    .clr_i      (xmodem_saw_invalid_block),
    .word       (word),
    .word_valid (word_valid)
  );

  assign size_w = ADDR_W'(word);

`ifdef SL_CHECKPOINT_EN
  sl_ctl_t           ck_ctl_q;
  logic [ADDR_W-1:0] ck_len_q;
  logic [ADDR_W-1:0] ck_off_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ck_ctl_q <= '{st: SL_SIZE, seg: '0};
      ck_len_q <= '0;
      ck_off_q <= '0;
    end else if (xmodem_saw_valid_block) begin
      ck_ctl_q <= ctl_d;
      ck_len_q <= len_d;
      ck_off_q <= off_d;
    end
  end
`else
  logic unused_vblk;
  assign unused_vblk = xmodem_saw_valid_block;
`endif

  always_comb begin
    ctl_d  = ctl_q;
    len_d  = len_q;
    off_d  = off_q;
    wr_req = 1'b0;
    if (word_valid) begin
      unique case (ctl_q.st)
        SL_SIZE: begin
          if (size_w != '0) begin
            ctl_d.st = SL_DATA;
            len_d    = size_w;
            off_d    = '0;
          end else begin
            ctl_d.seg = sl_next_seg(ctl_q.seg, NUM_SEGS);
          end
        end
        SL_DATA: begin
          wr_req = 1'b1;
          if (off_q == len_q - ONE) begin
            off_d     = '0;
            ctl_d.st  = SL_SIZE;
            ctl_d.seg = sl_next_seg(ctl_q.seg, NUM_SEGS);
          end else begin
            off_d = off_q + ONE;
          end
        end
      endcase
    end
`ifdef SL_CHECKPOINT_EN
    if (xmodem_saw_invalid_block) begin
      ctl_d = ck_ctl_q;
      len_d = ck_len_q;
      off_d = ck_off_q;
    end
`endif
  end

  // A word may load when the slot is empty or being freed this cycle.
  assign wr_load = wr_req & (~we_q | sl_ack);
  assign wr_lost = wr_req & we_q & ~sl_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctl_q  <= '{st: SL_SIZE, seg: '0};
      len_q  <= '0;
      off_q  <= '0;
      we_q   <= 1'b0;
      addr_q <= BASE0;
      io_q   <= '0;
      ovr_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      ctl_q <= ctl_d;
      len_q <= len_d;
      off_q <= off_d;
      if (wr_load) begin
        we_q   <= 1'b1;
        addr_q <= base_of(ctl_q.seg) + off_q;
        io_q   <= word;
      end else if (sl_ack) begin
        we_q <= 1'b0;
      end
      if (wr_lost)
        ovr_q <= 1'b1;
      if (xmodem_done)
        done_q <= 1'b1;
    end
  end

  assign sl_addr    = addr_q;
  assign sl_io      = io_q;
  assign sl_we      = we_q;
  assign sl_seg     = ctl_q.seg;
  assign sl_overrun = ovr_q;
  assign sl_done    = done_q;

endmodule

// File: tb/tb_multi_seg_loader.sv
// tb_multi_seg_loader: randomized scene loads checked against a
// segment/offset write-list model; second instance covers 64-bit words.
module tb_multi_seg_loader;

  localparam int AW = 25;
  localparam int DW = 32;
  localparam int NS = 3;
  localparam logic [AW-1:0] TB_T = 25'h000_0100;
  localparam logic [AW-1:0] TB_L = 25'h004_0000;
  localparam logic [AW-1:0] TB_I = 25'h100_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    dbyte = 8'h00;
  logic          stb = 1'b0;
  logic          vblk = 1'b0;
  logic          iblk = 1'b0;
  logic          xdone = 1'b0;
  logic          ack = 1'b0;
  logic [AW-1:0] addr;
  logic [DW-1:0] io;
  logic          we;
  logic [2:0]    seg;
  logic          ovr;
  logic          done;

  logic [7:0]    dbyte2 = 8'h00;
  logic          stb2 = 1'b0;
  logic          zero2 = 1'b0;
  logic          ack2 = 1'b1;
  logic [AW-1:0] addr2;
  logic [63:0]   io2;
  logic          we2;
  logic [2:0]    seg2;
  logic          ovr2;
  logic          done2;

  int checks = 0;
  int errors = 0;
  int ack_mode = 0;
  bit mon_en = 1'b0;
  int m_seg = 0;

  logic [AW+DW-1:0] got[$];
  logic [AW+DW-1:0] exp[$];

  multi_seg_loader #(
    .NUM_SEGS   (NS),
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .BASE_ADDRS ({TB_I, TB_L, TB_T})
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .xmodem_data_byte          (dbyte),
    .xmodem_saw_valid_msg_byte (stb),
    .xmodem_saw_valid_block    (vblk),
    .xmodem_saw_invalid_block  (iblk),
    .xmodem_done               (xdone),
    .sl_addr                   (addr),
    .sl_io                     (io),
    .sl_we                     (we),
    .sl_ack                    (ack),
    .sl_seg                    (seg),
    .sl_overrun                (ovr),
    .sl_done                   (done)
  );

  multi_seg_loader #(
    .NUM_SEGS   (2),
    .DATA_W     (64),
    .ADDR_W     (AW),
    .BASE_ADDRS ({TB_L, TB_T})
  ) dut64 (
    .clk                       (clk),
    .rst                       (rst),
    .xmodem_data_byte          (dbyte2),
    .xmodem_saw_valid_msg_byte (stb2),
    .xmodem_saw_valid_block    (zero2),
    .xmodem_saw_invalid_block  (zero2),
    .xmodem_done               (zero2),
    .sl_addr                   (addr2),
    .sl_io                     (io2),
    .sl_we                     (we2),
    .sl_ack                    (ack2),
    .sl_seg                    (seg2),
    .sl_overrun                (ovr2),
    .sl_done                   (done2)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // Memory side: picks ack for the next edge, logs accepted writes,
  // and checks a stalled write keeps its address and data.
  int            wait_cnt = 0;
  int            lowrun = 0;
  bit            pend = 1'b0;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_io;

  always @(negedge clk) begin
    if (mon_en && pend) begin
      checks++;
      if (we !== 1'b1 || addr !== p_addr || io !== p_io) begin
        errors++;
        $display("FAIL hold_stable we=%b addr=%h io=%h required we=1 addr=%h io=%h",
                 we, addr, io, p_addr, p_io);
      end
    end
    case (ack_mode)
      0: ack = 1'b1;
      1: ack = (lowrun >= 2) ? 1'b1 : ($urandom_range(0, 1) == 1);
      2: ack = 1'b0;
      default: ack = (wait_cnt >= 3);
    endcase
    if (mon_en && we) begin
      if (ack) begin
        got.push_back({addr, io});
        wait_cnt = 0;
        lowrun = 0;
      end else begin
        wait_cnt++;
        lowrun++;
      end
    end else begin
      wait_cnt = 0;
      lowrun = 0;
    end
    pend = mon_en && we && !ack;
    p_addr = addr;
    p_io = io;
  end

  int            n_w2 = 0;
  logic [AW-1:0] c_addr2;
  logic [63:0]   c_io2;

  always @(negedge clk) begin
    if (we2 && ack2) begin
      n_w2++;
      c_addr2 = addr2;
      c_io2 = io2;
    end
  end

  function automatic logic [AW-1:0] base(input int s);
    case (s)
      0: return TB_T;
      1: return TB_L;
      default: return TB_I;
    endcase
  endfunction

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    stb = 1'b0;
    vblk = 1'b0;
    iblk = 1'b0;
    xdone = 1'b0;
    stb2 = 1'b0;
    ack_mode = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    got.delete();
    exp.delete();
    m_seg = 0;
    mon_en = 1'b1;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    stb = 1'b0;
    vblk = 1'b0;
    iblk = 1'b0;
    xdone = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    dbyte = b;
    stb = 1'b1;
    if (gap > 0) begin
      @(negedge clk);
      stb = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--)
      send_byte(w[i*8 +: 8], gap);
  endtask

  task automatic run_segment(input int size, input int gap);
    logic [31:0] w;
    send_word(32'(size), gap);
    for (int i = 0; i < size; i++) begin
      w = $urandom;
      exp.push_back({base(m_seg) + AW'(i), w});
      send_word(w, gap);
    end
    m_seg = (m_seg + 1) % NS;
  endtask

  task automatic drain();
    for (int c = 0; c < 40 && got.size() < exp.size(); c++)
      @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (we !== 1'b0) begin errors++; $display("FAIL reset_we got %b required 0", we); end
    checks++;
    if (io !== '0) begin errors++; $display("FAIL reset_io got %h required 0", io); end
    checks++;
    if (addr !== TB_T) begin errors++; $display("FAIL reset_addr got %h required %h", addr, TB_T); end
    checks++;
    if (seg !== 3'd0) begin errors++; $display("FAIL reset_seg got %0d required 0", seg); end
    checks++;
    if (ovr !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_flags got ovr=%b done=%b required 0 0", ovr, done);
    end
  endtask

  task automatic test_basic();
    int sizes[3] = '{2, 1, 3};
    do_reset();
    foreach (sizes[k]) begin
      run_segment(sizes[k], 1);
      idle(2);
      checks++;
      if (seg !== 3'(m_seg)) begin
        errors++; $display("FAIL basic_seg got %0d required %0d", seg, m_seg);
      end
    end
    drain();
    checks++;
    if (got.size() != exp.size()) begin errors++; $display("FAIL basic_count got %0d required %0d", got.size(), exp.size()); end
    foreach (exp[i]) if (i < got.size()) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL basic_write[%0d] got %h required %h", i, got[i], exp[i]); end
    end
    checks++;
    if (ovr !== 1'b0) begin errors++; $display("FAIL basic_ovr got %b required 0", ovr); end
  endtask

  task automatic test_zero_len();
    int sizes[3] = '{1, 0, 2};
    do_reset();
    foreach (sizes[k]) begin
      run_segment(sizes[k], 1);
      idle(2);
      checks++;
      if (seg !== 3'(m_seg)) begin
        errors++; $display("FAIL zero_seg got %0d required %0d", seg, m_seg);
      end
    end
    drain();
    checks++;
    if (got.size() != exp.size()) begin errors++; $display("FAIL zero_count got %0d required %0d", got.size(), exp.size()); end
    foreach (exp[i]) if (i < got.size()) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL zero_write[%0d] got %h required %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_random();
    do_reset();
    ack_mode = 1;
    for (int k = 0; k < 2 * NS + 1; k++)
      run_segment($urandom_range(0, 4), 1);
    idle(2);
    drain();
    checks++;
    if (seg !== 3'(m_seg)) begin errors++; $display("FAIL rand_seg got %0d required %0d", seg, m_seg); end
    checks++;
    if (got.size() != exp.size()) begin errors++; $display("FAIL rand_count got %0d required %0d", got.size(), exp.size()); end
    foreach (exp[i]) if (i < got.size()) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL rand_write[%0d] got %h required %h", i, got[i], exp[i]); end
    end
    checks++;
    if (ovr !== 1'b0) begin errors++; $display("FAIL rand_ovr got %b required 0", ovr); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ack_mode = 3;
    run_segment(4, 0);
    idle(1);
    drain();
    checks++;
    if (got.size() != exp.size()) begin errors++; $display("FAIL b2b_count got %0d required %0d", got.size(), exp.size()); end
    foreach (exp[i]) if (i < got.size()) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL b2b_write[%0d] got %h required %h", i, got[i], exp[i]); end
    end
    checks++;
    if (ovr !== 1'b0) begin errors++; $display("FAIL b2b_ovr got %b required 0", ovr); end
  endtask

  task automatic test_overrun();
    logic [31:0] w[5];
    do_reset();
    ack_mode = 2;
    foreach (w[i]) w[i] = $urandom;
    send_word(32'd5, 1);
    for (int i = 0; i < 4; i++) send_word(w[i], 1);
    idle(2);
    checks++;
    if (we !== 1'b1 || addr !== TB_T || io !== w[0]) begin
      errors++;
      $display("FAIL ovr_hold got we=%b addr=%h io=%h required 1 %h %h", we, addr, io, TB_T, w[0]);
    end
    checks++;
    if (ovr !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b required 1", ovr); end
    ack_mode = 0;
    idle(3);
    send_word(w[4], 1);
    idle(2);
    exp.push_back({TB_T, w[0]});
    exp.push_back({TB_T + AW'(4), w[4]});
    drain();
    checks++;
    if (got.size() != exp.size()) begin errors++; $display("FAIL ovr_count got %0d required %0d", got.size(), exp.size()); end
    foreach (exp[i]) if (i < got.size()) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL ovr_write[%0d] got %h required %h", i, got[i], exp[i]); end
    end
    checks++;
    if (seg !== 3'd1) begin errors++; $display("FAIL ovr_seg got %0d required 1", seg); end
  endtask

  task automatic test_invalid();
    logic [31:0] w;
    do_reset();
    w = $urandom;
    send_word(32'd1, 1);
    @(negedge clk); vblk = 1'b1;
    @(negedge clk); vblk = 1'b0;
    send_byte(8'hA5, 1);
    send_byte(8'h5A, 1);
    @(negedge clk);
    dbyte = 8'hEE; stb = 1'b1; iblk = 1'b1;
    idle(2);
    send_word(w, 1);
    idle(2);
    exp.push_back({TB_T, w});
    drain();
    checks++;
    if (got.size() != exp.size()) begin errors++; $display("FAIL inv_count got %0d required %0d", got.size(), exp.size()); end
    foreach (exp[i]) if (i < got.size()) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL inv_write[%0d] got %h required %h", i, got[i], exp[i]); end
    end
    checks++;
    if (seg !== 3'd1) begin errors++; $display("FAIL inv_seg got %0d required 1", seg); end
  endtask

`ifdef SL_CHECKPOINT_EN
  task automatic test_checkpoint();
    logic [31:0] w[3];
    do_reset();
    foreach (w[i]) w[i] = $urandom;
    send_word(32'd3, 1);
    send_word(w[0], 1);
    @(negedge clk); vblk = 1'b1;
    @(negedge clk); vblk = 1'b0;
    send_word(w[1], 1);
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    @(negedge clk); iblk = 1'b1;
    idle(2);
    send_word(w[1], 1);
    send_word(w[2], 1);
    idle(2);
    exp.push_back({TB_T, w[0]});
    exp.push_back({TB_T + AW'(1), w[1]});
    exp.push_back({TB_T + AW'(1), w[1]});
    exp.push_back({TB_T + AW'(2), w[2]});
    drain();
    checks++;
    if (got.size() != exp.size()) begin errors++; $display("FAIL ckpt_count got %0d required %0d", got.size(), exp.size()); end
    foreach (exp[i]) if (i < got.size()) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL ckpt_write[%0d] got %h required %h", i, got[i], exp[i]); end
    end
    checks++;
    if (seg !== 3'd1) begin errors++; $display("FAIL ckpt_seg got %0d required 1", seg); end
  endtask
`endif

  task automatic test_done();
    do_reset();
    send_word(32'd1, 1);
    send_byte(8'h12, 1);
    send_byte(8'h34, 1);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_early got %b required 0", done); end
    @(negedge clk); xdone = 1'b1;
    @(negedge clk); xdone = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL done_set got %b required 1", done); end
    send_word($urandom, 1);
    send_word($urandom, 1);
    idle(4);
    checks++;
    if (got.size() != 0 || we !== 1'b0) begin
      errors++; $display("FAIL done_ignore got writes=%0d we=%b required 0 0", got.size(), we);
    end
    checks++;
    if (done !== 1'b1 || seg !== 3'd0) begin
      errors++; $display("FAIL done_hold got done=%b seg=%0d required 1 0", done, seg);
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    ack_mode = 2;
    send_word(32'd2, 1);
    send_word($urandom, 1);
    idle(1);
    checks++;
    if (we !== 1'b1) begin errors++; $display("FAIL rmw_pre got we=%b required 1", we); end
    mon_en = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (we !== 1'b0 || addr !== TB_T || io !== '0 || seg !== 3'd0 || ovr !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rmw_async got we=%b addr=%h io=%h seg=%0d ovr=%b done=%b required 0 %h 0 0 0 0",
               we, addr, io, seg, ovr, done, TB_T);
    end
    @(negedge clk);
    rst = 1'b1;
    ack_mode = 0;
    got.delete();
    mon_en = 1'b1;
    idle(10);
    checks++;
    if (got.size() != 0 || we !== 1'b0) begin
      errors++; $display("FAIL rmw_replay got writes=%0d we=%b required 0 0", got.size(), we);
    end
  endtask

  task automatic test_wide();
    logic [63:0] sz;
    logic [63:0] v;
    sz = 64'd1;
    v = 64'h0102_0304_0506_0708;
    do_reset();
    n_w2 = 0;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk); dbyte2 = sz[i*8 +: 8]; stb2 = 1'b1;
      @(negedge clk); stb2 = 1'b0;
    end
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk); dbyte2 = v[i*8 +: 8]; stb2 = 1'b1;
      @(negedge clk); stb2 = 1'b0;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (n_w2 != 1) begin errors++; $display("FAIL wide_count got %0d required 1", n_w2); end
    checks++;
    if (c_io2 !== v || c_addr2 !== TB_T) begin
      errors++; $display("FAIL wide_write got %h@%h required %h@%h", c_io2, c_addr2, v, TB_T);
    end
    checks++;
    if (seg2 !== 3'd1) begin errors++; $display("FAIL wide_seg got %0d required 1", seg2); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_random();
    test_back_to_back();
    test_overrun();
    test_invalid();
`ifdef SL_CHECKPOINT_EN
    test_checkpoint();
`endif
    test_done();
    test_reset_mid_write();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
